// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and constants for the dot-product controller.
// Holds the FSM state type, datapath latency and datapath output width helper.
package dot_product_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam int DP_LATENCY = 2;

    // Width of the redundant sum/carry words produced by the external datapath.
    function automatic int dp_out_width(input int in0, input int in1, input int arr);
        return in0 + in1 + 2 * ($clog2(((in1 + 2) / 3) * arr) - 1);
    endfunction

endpackage

// File: rtl/dot_acc_unit.sv
// Tracks chunks in flight through the external datapath and accumulates
// the resolved sum/carry words as they emerge.
module dot_acc_unit
    import dot_product_ctrl_pkg::*;
#(
    parameter int DP_OUT_W = 20,
    parameter int ACC_SIZE = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_issue,
    input  logic                i_clear,
    input  logic [DP_OUT_W-1:0] i_dp_sum,
    input  logic [DP_OUT_W-1:0] i_dp_carry,
    output logic [ACC_SIZE-1:0] o_acc,
    output logic                o_acc_en,
    output logic                o_pending
);

    logic [DP_LATENCY-1:0] r_vld;
    logic [ACC_SIZE-1:0]   r_acc;
    logic [DP_OUT_W-1:0]   w_dpWord;
    logic [ACC_SIZE-1:0]   w_dpExt;

    // Collapse the redundant form, then sign-extend into the accumulator width.
    assign w_dpWord  = i_dp_sum + i_dp_carry;
    assign w_dpExt   = {{(ACC_SIZE - DP_OUT_W){w_dpWord[DP_OUT_W-1]}}, w_dpWord};
    assign o_acc_en  = r_vld[DP_LATENCY-1];
    assign o_pending = |r_vld[DP_LATENCY-2:0];
    assign o_acc     = r_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
            r_acc <= '0;
        end else begin
            r_vld <= {r_vld[DP_LATENCY-2:0], i_issue};
            if (i_clear) begin
                r_acc <= '0;
            end else if (o_acc_en) begin
                r_acc <= r_acc + w_dpExt;
            end
        end
    end

endmodule

// File: rtl/dot_product_ctrl.sv
// Job controller: accepts a chunk count, streams chunks to an external
// 2-cycle dot-product datapath, and returns the accumulated result.
module dot_product_ctrl
    import dot_product_ctrl_pkg::*;
#(
    parameter  int IN_SIZE_0  = 4,
    parameter  int IN_SIZE_1  = 8,
    parameter  int ARRAY_SIZE = 8,
    parameter  int MAX_CHUNKS = 256,
    parameter  int ACC_SIZE   = 32,
    localparam int DP_OUT_W   = dp_out_width(IN_SIZE_0, IN_SIZE_1, ARRAY_SIZE),
    localparam int LEN_W      = $clog2(MAX_CHUNKS) + 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  cfg_valid_i,
    output logic                                  cfg_ready_o,
    input  logic [LEN_W-1:0]                      cfg_len_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0]  in_0_i,
    input  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0]  in_1_i,
    output logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0]  dp_in_0_o,
    output logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0]  dp_in_1_o,
    input  logic [DP_OUT_W-1:0]                   dp_sum_i,
    input  logic [DP_OUT_W-1:0]                   dp_carry_i,
    output logic                                  res_valid_o,
    input  logic                                  res_ready_i,
    output logic [ACC_SIZE-1:0]                   res_data_o,
    output logic                                  busy_o
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic               w_cfgFire;
    logic               w_inFire;
    logic [LEN_W-1:0]   w_lenClamped;
    logic               w_accEn;
    logic               w_pending;
    logic [ACC_SIZE-1:0] w_acc;

    assign w_cfgFire    = cfg_valid_i && (r_state == ST_IDLE);
    assign w_inFire     = in_valid_i && (r_state == ST_RUN);
    assign w_lenClamped = (cfg_len_i > LEN_W'(MAX_CHUNKS)) ? LEN_W'(MAX_CHUNKS) : cfg_len_i;

    assign cfg_ready_o  = (r_state == ST_IDLE);
    assign in_ready_o   = (r_state == ST_RUN);
    assign res_valid_o  = (r_state == ST_RESULT);
    assign busy_o       = (r_state != ST_IDLE);
    assign res_data_o   = w_acc;

    // Operands only reach the datapath on an accepted chunk.
    assign dp_in_0_o    = w_inFire ? in_0_i : '0;
    assign dp_in_1_o    = w_inFire ? in_1_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cfgFire) begin
                        r_remaining <= w_lenClamped;
                        r_state     <= (w_lenClamped == '0) ? ST_RESULT : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_inFire) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                // Leave once the last in-flight result is being captured.
                ST_DRAIN: begin
                    if (w_accEn && !w_pending) begin
                        r_state <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dot_acc_unit #(
        .DP_OUT_W (DP_OUT_W),
        .ACC_SIZE (ACC_SIZE)
    ) u_acc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_issue    (w_inFire),
        .i_clear    (w_cfgFire),
        .i_dp_sum   (dp_sum_i),
        .i_dp_carry (dp_carry_i),
        .o_acc      (w_acc),
        .o_acc_en   (w_accEn),
        .o_pending  (w_pending)
    );

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed self-checking bench for dot_product_ctrl with a 2-cycle
// registered dot-product datapath model returning a split sum/carry pair.
module tb_dot_product_ctrl;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic [8:0]           cfg_len_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [7:0][3:0]      in_0_i;
    logic [7:0][7:0]      in_1_i;
    logic [7:0][3:0]      dp_in_0_o;
    logic [7:0][7:0]      dp_in_1_o;
    logic [19:0]          dp_sum_i;
    logic [19:0]          dp_carry_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [31:0]          res_data_o;
    logic                 busy_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int len;
        int a;
        int b;
        int gap;
        int hold;
        int expected;
    } vec_t;

    vec_t vecs[7];

    always #5 clk_i = ~clk_i;

    dot_product_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_len_i   (cfg_len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_0_i      (in_0_i),
        .in_1_i      (in_1_i),
        .dp_in_0_o   (dp_in_0_o),
        .dp_in_1_o   (dp_in_1_o),
        .dp_sum_i    (dp_sum_i),
        .dp_carry_i  (dp_carry_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .busy_o      (busy_o)
    );

    // Datapath model: operands registered, then the dot product registered.
    logic [7:0][3:0] m0;
    logic [7:0][7:0] m1;
    logic [19:0]     mDot;

    function automatic logic [19:0] dotOf(input logic [7:0][3:0] a, input logic [7:0][7:0] b);
        int s;
        s = 0;
        for (int l = 0; l < 8; l++) s += $signed(a[l]) * $signed(b[l]);
        return 20'(s);
    endfunction

    always @(posedge clk_i) begin
        m0   <= dp_in_0_o;
        m1   <= dp_in_1_o;
        mDot <= dotOf(m0, m1);
    end

    assign dp_carry_i = 20'd5;
    assign dp_sum_i   = mDot - 20'd5;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int n;
        int cnt;
        logic [7:0][3:0] e0;
        logic [7:0][7:0] e1;
        n = (v.len > 256) ? 256 : v.len;
        for (int l = 0; l < 8; l++) begin
            e0[l] = 4'(v.a);
            e1[l] = 8'(v.b);
        end
        cfg_len_i   = 9'(v.len);
        cfg_valid_i = 1'b1;
        #1;
        checkOutput($sformatf("v%0d_cfg_ready", idx), 32'(cfg_ready_o), 32'd1);
        step();
        cfg_valid_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    in_valid_i = 1'b0;
                    in_0_i     = '1;
                    in_1_i     = '1;
                    #1;
                    if (k == 1 && g == 0)
                        checkOutput($sformatf("v%0d_bubble_dp0", idx), 32'(dp_in_0_o), 32'd0);
                    step();
                end
            end
            in_valid_i = 1'b1;
            in_0_i     = e0;
            in_1_i     = e1;
            #1;
            if (k == 0) begin
                checkOutput($sformatf("v%0d_in_ready", idx), 32'(in_ready_o), 32'd1);
                checkOutput($sformatf("v%0d_run_cfg_ready", idx), 32'(cfg_ready_o), 32'd0);
                checkOutput($sformatf("v%0d_dp_in_0", idx), 32'(dp_in_0_o), 32'(e0));
                checkOutput($sformatf("v%0d_dp_in_1", idx), 32'(dp_in_1_o), 32'(e1));
            end
            step();
        end
        in_valid_i = 1'b0;
        cnt = 1;
        while (!res_valid_o && cnt < 20) begin
            step();
            cnt++;
        end
        checkOutput($sformatf("v%0d_latency", idx), 32'(cnt), (n == 0) ? 32'd1 : 32'd3);
        checkOutput($sformatf("v%0d_result", idx), res_data_o, 32'(v.expected));
        for (int h = 0; h < v.hold; h++) begin
            step();
            checkOutput($sformatf("v%0d_hold%0d_valid", idx, h), 32'(res_valid_o), 32'd1);
            checkOutput($sformatf("v%0d_hold%0d_data", idx, h), res_data_o, 32'(v.expected));
            checkOutput($sformatf("v%0d_hold%0d_cfg_ready", idx, h), 32'(cfg_ready_o), 32'd0);
            checkOutput($sformatf("v%0d_hold%0d_in_ready", idx, h), 32'(in_ready_o), 32'd0);
        end
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        checkOutput($sformatf("v%0d_post_valid", idx), 32'(res_valid_o), 32'd0);
        checkOutput($sformatf("v%0d_post_busy", idx), 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        vec_t tail;
        vecs[0] = '{len: 1,   a: 1,  b: 2,    gap: 0, hold: 0, expected: 16};
        vecs[1] = '{len: 4,   a: -1, b: 127,  gap: 0, hold: 0, expected: -4064};
        vecs[2] = '{len: 3,   a: 3,  b: -5,   gap: 2, hold: 0, expected: -360};
        vecs[3] = '{len: 3,   a: 3,  b: -5,   gap: 0, hold: 5, expected: -360};
        vecs[4] = '{len: 0,   a: 0,  b: 0,    gap: 0, hold: 0, expected: 0};
        vecs[5] = '{len: 2,   a: -8, b: -128, gap: 0, hold: 0, expected: 16384};
        vecs[6] = '{len: 300, a: 1,  b: 1,    gap: 0, hold: 0, expected: 2048};

        rst_i       = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_len_i   = '0;
        in_valid_i  = 1'b0;
        in_0_i      = '0;
        in_1_i      = '0;
        res_ready_i = 1'b0;
        step();
        step();
        checkOutput("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
        checkOutput("rst_in_ready", 32'(in_ready_o), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid_o), 32'd0);
        checkOutput("rst_res_data", res_data_o, 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;

        in_valid_i = 1'b1;
        in_0_i     = '1;
        in_1_i     = '1;
        #1;
        checkOutput("idle_dp_in_0", 32'(dp_in_0_o), 32'd0);
        checkOutput("idle_in_ready", 32'(in_ready_o), 32'd0);
        step();
        in_valid_i = 1'b0;

        for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

        // Abort a long job with chunks still in flight, then run a short one.
        cfg_len_i   = 9'd8;
        cfg_valid_i = 1'b1;
        step();
        cfg_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_i = 1'b1;
            for (int l = 0; l < 8; l++) begin
                in_0_i[l] = 4'd5;
                in_1_i[l] = 8'd7;
            end
            step();
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        checkOutput("abort_cfg_ready", 32'(cfg_ready_o), 32'd1);
        checkOutput("abort_in_ready", 32'(in_ready_o), 32'd0);
        checkOutput("abort_res_valid", 32'(res_valid_o), 32'd0);
        checkOutput("abort_res_data", res_data_o, 32'd0);
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        checkOutput("abort_dp_in_0", 32'(dp_in_0_o), 32'd0);
        step();
        in_valid_i = 1'b0;
        step();
        checkOutput("abort_drained_data", res_data_o, 32'd0);
        tail = '{len: 1, a: 1, b: 2, gap: 0, hold: 0, expected: 16};
        applyStimulus(7, tail);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
